// File: rtl/pdu_uart_interface_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pdu_uart_interface_if : register bus between host and the UART block
// Rev 1.0
// ---------------------------------------------------------------------------
interface pdu_uart_interface_if;
  logic [31:0] uart_interface_addr;
  logic [31:0] uart_interface_rdata;
  logic [31:0] uart_interface_wdata;
  logic        uart_interface_we;

  modport master (
    output uart_interface_addr,
    output uart_interface_wdata,
    output uart_interface_we,
    input  uart_interface_rdata
  );

  modport slave (
    input  uart_interface_addr,
    input  uart_interface_wdata,
    input  uart_interface_we,
    output uart_interface_rdata
  );
endinterface
`default_nettype wire

// File: rtl/pdu_uart_interface.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pdu_uart_interface : register-mapped 8N1 UART with TX and RX FIFOs
// Rev 1.0
// ---------------------------------------------------------------------------
module pdu_uart_interface #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  pdu_uart_interface_if.slave  bus,
  output logic                 uart_txd,
  input  logic                 uart_rxd
);

  localparam int DIV   = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W = $clog2(DIV);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW1   = PTR_W + 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BAUD_HALF = CNT_W'(DIV / 2 - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = CW1'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  logic [7:0] off;
  logic       wr_tx, wr_rx, wr_st;
  logic       unused_bits;

  assign off         = bus.uart_interface_addr[7:0];
  assign wr_tx       = bus.uart_interface_we && (off == 8'h00);
  assign wr_rx       = bus.uart_interface_we && (off == 8'h04);
  assign wr_st       = bus.uart_interface_we && (off == 8'h08);
  assign unused_bits = ^{bus.uart_interface_addr[31:8], bus.uart_interface_wdata[31:8]};

  // ---------------- TX FIFO ----------------
  logic [7:0]       tx_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_wp_q, tx_rp_q;
  logic [PTR_W:0]   tx_cnt_q;
  logic             tx_pop, tx_push;
  state_e           tx_state_q, tx_state_d;

  assign tx_pop  = (tx_state_q == IDLE) && (tx_cnt_q != '0);
  assign tx_push = wr_tx && ((tx_cnt_q != FIFO_FULL) || tx_pop);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= bus.uart_interface_wdata[7:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_q <= tx_cnt_q + 1'b1;
        2'b01:   tx_cnt_q <= tx_cnt_q - 1'b1;
        default: tx_cnt_q <= tx_cnt_q;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  logic [CNT_W-1:0] tx_baud_q, tx_baud_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state_q <= IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      IDLE: begin
        if (tx_pop) begin
          tx_shift_d = tx_mem_q[tx_rp_q];
          tx_baud_d  = '0;
          tx_state_d = START;
        end
      end
      START: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d  = '0;
          tx_bit_d   = '0;
          tx_state_d = DATA;
        end else begin
          tx_baud_d = tx_baud_q + 1'b1;
        end
      end
      DATA: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d  = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = STOP;
          else                  tx_bit_d   = tx_bit_q + 1'b1;
        end else begin
          tx_baud_d = tx_baud_q + 1'b1;
        end
      end
      default: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d  = '0;
          tx_state_d = IDLE;
        end else begin
          tx_baud_d = tx_baud_q + 1'b1;
        end
      end
    endcase
  end

  // Decoded straight from state so an asynchronous reset forces the line idle at once.
  assign uart_txd = (tx_state_q == START) ? 1'b0 :
                    (tx_state_q == DATA)  ? tx_shift_q[0] : 1'b1;

  // ---------------- RX synchronizer + FSM ----------------
  logic [1:0]       rx_sync_q;
  logic             rx_prev_q, rx_s, rx_done;
  state_e           rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_baud_q, rx_baud_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;

  assign rx_s = rx_sync_q[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], uart_rxd};
      rx_prev_q  <= rx_s;
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s) begin
          rx_baud_d  = '0;
          rx_state_d = START;
        end
      end
      START: begin
        // Mid-start re-check: a line back high here was only a glitch.
        if (rx_baud_q == BAUD_HALF) begin
          rx_baud_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s ? IDLE : DATA;
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
      DATA: begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d  = '0;
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = STOP;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
      default: begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d  = '0;
          rx_done    = rx_s;
          rx_state_d = IDLE;
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]       rx_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rx_wp_q, rx_rp_q;
  logic [PTR_W:0]   rx_cnt_q;
  logic             rx_pop, rx_push, rx_ovr_q;

  assign rx_pop  = wr_rx && (rx_cnt_q != '0);
  assign rx_push = rx_done && ((rx_cnt_q != FIFO_FULL) || rx_pop);

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_shift_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      rx_ovr_q <= 1'b0;
    end else begin
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_q <= rx_cnt_q + 1'b1;
        2'b01:   rx_cnt_q <= rx_cnt_q - 1'b1;
        default: rx_cnt_q <= rx_cnt_q;
      endcase
      if (rx_done && !rx_push)                         rx_ovr_q <= 1'b1;
      else if (wr_st && bus.uart_interface_wdata[3])   rx_ovr_q <= 1'b0;
    end
  end

  // ---------------- Read mux ----------------
  always_comb begin
    bus.uart_interface_rdata = '0;
    case (off)
      8'h04: bus.uart_interface_rdata = (rx_cnt_q != '0) ? {24'h0, rx_mem_q[rx_rp_q]} : 32'h0;
      8'h08: bus.uart_interface_rdata = {27'h0, (tx_state_q != IDLE), rx_ovr_q,
                                         (rx_cnt_q != '0), (tx_cnt_q == '0),
                                         (tx_cnt_q == FIFO_FULL)};
      default: bus.uart_interface_rdata = '0;
    endcase
  end

endmodule
`default_nettype wire
